// File: rtl/keccak_gather_pkg.sv
// Shared keccak definitions: block geometry, gather FSM states and the
// word-index to bit-offset mapping used by both the divider and the gatherer.
package keccak_gather_pkg;

  localparam int KECCAK_BLK_W  = 512;
  localparam int KECCAK_WORD_W = 32;
  localparam int KECCAK_NWORDS = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } keccak_state_e;

  // Word k of a block occupies bits [32k+31:32k].
  function automatic int unsigned keccak_word_offset(input int unsigned k);
    return k * KECCAK_WORD_W;
  endfunction

endpackage

// File: rtl/keccak_gather_slot.sv
// One block word: a register with load enable, zeroed by synchronous reset.
module keccak_gather_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/keccak_gather.sv
// Gathers sixteen 32-bit CPU words into a 512-bit block and offers it to
// keccak_ctrl over a valid/ready handshake once every slot has been written.
module keccak_gather
  import keccak_gather_pkg::*;
#(
  parameter int WORD_W  = KECCAK_WORD_W,
  parameter int N_WORDS = KECCAK_NWORDS,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      wr,
  input  logic [5:0]                num,
  input  logic [WORD_W-1:0]         in32,
  input  logic                      clear,
  output logic [WORD_W*N_WORDS-1:0] out512,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [4:0]                fill_count,
  output logic                      dup_err,
  output logic                      ovf_err
);

  keccak_state_e      state_q;
  logic [N_WORDS-1:0] mask_q;
  logic [N_WORDS-1:0] mask_d;
  logic [N_WORDS-1:0] slot_bit;
  logic [4:0]         fill_q;
  logic               dup_q;
  logic               ovf_q;

  logic [IDX_W-1:0]   idx;
  logic               wr_strobe;
  logic               wr_acc;
  logic               slot_hit;
  logic               unused_num;

  // The upper num bits carry no slot information.
  assign idx        = num[IDX_W-1:0];
  assign unused_num = ^num[5:IDX_W];

  assign wr_strobe = en & wr;
  assign wr_acc    = wr_strobe & (state_q == FILL) & ~clear;
  assign slot_bit  = N_WORDS'(1) << idx;
  assign slot_hit  = |(mask_q & slot_bit);
  assign mask_d    = mask_q | slot_bit;

  genvar k;
  generate
    for (k = 0; k < N_WORDS; k++) begin : g_slot
      logic [WORD_W-1:0] slot_q;

      keccak_gather_slot #(
        .W (WORD_W)
      ) u_slot (
        .clk  (clk),
        .rst  (rst),
        .ld_i (wr_acc && (idx == IDX_W'(k))),
        .d_i  (in32),
        .q_o  (slot_q)
      );

      assign out512[keccak_word_offset(k) +: WORD_W] = slot_q;
    end
  endgenerate

  // clear outranks both a write and the handshake; the data words survive it.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= FILL;
      mask_q  <= '0;
      fill_q  <= '0;
      dup_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (wr_acc) begin
            mask_q <= mask_d;
            if (slot_hit) begin
              dup_q <= 1'b1;
            end else begin
              fill_q <= fill_q + 5'd1;
            end
            if (&mask_d) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (wr_strobe) begin
            ovf_q <= 1'b1;
          end
          if (out_ready) begin
            mask_q  <= '0;
            fill_q  <= '0;
            state_q <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q == HOLD);
  assign fill_count = fill_q;
  assign dup_err    = dup_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_keccak_gather.sv
// Directed and randomized self-checking bench for keccak_gather against a
// slot-array reference model of the gather rules.
module tb_keccak_gather;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         wr = 1'b0;
  logic [5:0]   num = '0;
  logic [31:0]  in32 = '0;
  logic         clear = 1'b0;
  logic         out_ready = 1'b0;
  logic [511:0] out512;
  logic         out_valid;
  logic         busy;
  logic [4:0]   fill_count;
  logic         dup_err;
  logic         ovf_err;

  int checks = 0;
  int errors = 0;

  // Reference model: per-slot data and "written" flags plus the block/flag state.
  logic [31:0] mData [16];
  bit          mFilled [16];
  bit          mHold, mDup, mOvf;

  keccak_gather dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr         (wr),
    .num        (num),
    .in32       (in32),
    .clear      (clear),
    .out512     (out512),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .fill_count (fill_count),
    .dup_err    (dup_err),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < 16; i++) n += mFilled[i] ? 1 : 0;
    return n;
  endfunction

  // Apply the gather rules to the model for one clock edge, using the inputs
  // that were present at that edge.
  task automatic modelStep();
    bit wasHold = mHold;
    int s = int'(num[3:0]);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mData[i] = '0;
        mFilled[i] = 1'b0;
      end
      mHold = 0; mDup = 0; mOvf = 0;
    end else if (clear) begin
      for (int i = 0; i < 16; i++) mFilled[i] = 1'b0;
      mHold = 0; mDup = 0; mOvf = 0;
    end else if (wasHold) begin
      if (en && wr) mOvf = 1;
      if (out_ready) begin
        for (int i = 0; i < 16; i++) mFilled[i] = 1'b0;
        mHold = 0;
      end
    end else if (en && wr) begin
      if (mFilled[s]) mDup = 1;
      mData[s] = in32;
      mFilled[s] = 1'b1;
      if (modelCount() == 16) mHold = 1;
    end
  endtask

  task automatic checkOutput();
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = mData[i];
    check("out512", out512, blk);
    check("out_valid", 512'(out_valid), 512'(mHold));
    check("busy", 512'(busy), 512'(mHold));
    check("fill_count", 512'(fill_count), 512'(modelCount()));
    check("dup_err", 512'(dup_err), 512'(mDup));
    check("ovf_err", 512'(ovf_err), 512'(mOvf));
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit w, input logic [5:0] n,
                               input logic [31:0] d, input bit c, input bit rdy);
    rst = r; en = e; wr = w; num = n; in32 = d; clear = c; out_ready = rdy;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic writeSlot(input logic [5:0] n, input logic [31:0] d);
    applyStimulus(0, 1, 1, n, d, 0, 0);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(0, 1, 0, '0, '0, 0, rdy);
  endtask

  initial begin
    logic [511:0] expBlk;
    for (int i = 0; i < 16; i++) begin
      mData[i] = '0;
      mFilled[i] = 1'b0;
    end
    mHold = 0; mDup = 0; mOvf = 0;

    // Reset state
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    applyStimulus(1, 0, 0, '0, '0, 0, 0);
    check("reset out512", out512, '0);

    // In-order fill, then hold with ready low for 5 cycles before accepting
    for (int k = 0; k < 16; k++) writeSlot(6'(k), 32'h1000_0000 + 32'(k));
    check("inorder valid", 512'(out_valid), 512'(1));
    check("inorder count", 512'(fill_count), 512'(16));
    check("inorder word0", 512'(out512[31:0]), 512'(32'h1000_0000));
    check("inorder word15", 512'(out512[511:480]), 512'(32'h1000_000F));
    for (int i = 0; i < 5; i++) idle(0);
    check("hold valid", 512'(out_valid), 512'(1));
    idle(1);
    check("accept valid", 512'(out_valid), 512'(0));

    // Reverse order with num[5:4]=11 must land in the same slots
    for (int k = 15; k >= 0; k--) writeSlot({2'b11, 4'(k)}, 32'h1000_0000 + 32'(k));
    for (int i = 0; i < 16; i++) expBlk[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    check("reverse block", out512, expBlk);
    check("reverse valid", 512'(out_valid), 512'(1));
    idle(1);

    // Duplicate write to slot 3, then a write during HOLD
    writeSlot(6'd3, 32'hAAAA_AAAA);
    for (int k = 0; k < 16; k++) begin
      if (k == 3) writeSlot(6'd3, 32'h5555_5555);
      else writeSlot(6'(k), 32'h2000_0000 + 32'(k));
    end
    check("dup flag", 512'(dup_err), 512'(1));
    check("dup word3", 512'(out512[127:96]), 512'(32'h5555_5555));
    writeSlot(6'd0, 32'hDEAD_BEEF);
    check("ovf flag", 512'(ovf_err), 512'(1));
    check("ovf word0", 512'(out512[31:0]), 512'(32'h2000_0000));
    check("ovf busy", 512'(busy), 512'(1));
    applyStimulus(0, 1, 1, 6'd1, 32'h1234_5678, 0, 1);
    applyStimulus(0, 1, 0, '0, '0, 1, 0);

    // Clear together with a write aborts the partial block
    for (int k = 0; k < 8; k++) writeSlot(6'(k), 32'h3000_0000 + 32'(k));
    applyStimulus(0, 1, 1, 6'd8, 32'hCAFE_F00D, 1, 0);
    check("clear count", 512'(fill_count), 512'(0));
    check("clear word8", 512'(out512[287:256]), 512'(32'h2000_0008));
    for (int k = 0; k < 16; k++) writeSlot(6'(k), 32'h4000_0000 + 32'(k));
    check("post-clear valid", 512'(out_valid), 512'(1));
    idle(1);

    // Reset while HOLD with ready high
    for (int k = 0; k < 16; k++) writeSlot(6'(k), 32'h5000_0000 + 32'(k));
    applyStimulus(1, 1, 0, '0, '0, 0, 1);
    check("rst out512", out512, '0);
    check("rst valid", 512'(out_valid), 512'(0));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 7),
                    6'($urandom_range(0, 63)),
                    $urandom,
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 9) < 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_gather.md
Name: keccak_gather

Overview:
- Write-side counterpart of the 512-bit to 32-bit word divider that feeds results back to the CPU.
- Collects sixteen 32-bit words written by custom instructions into one 512-bit block.
- Word slot is selected by `num`, using the same word-to-bit-range mapping as the divider.
- Once all slots are filled, presents the block to keccak_ctrl over a valid/ready handshake.

Parameters:
- WORD_W, 32, width of one CPU word.
- N_WORDS, 16, words per block (block width = WORD_W*N_WORDS = 512).
- IDX_W, 4, slot index bits taken from num[IDX_W-1:0].

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  block enable; when 0, writes are ignored (handshake and clear still work).
- wr  in  1  write strobe for in32 into slot num.
- num  in  6  slot select (= cust5_limm); only num[3:0] is used, num[5:4] is ignored.
- in32  in  32  word from CPU.
- clear  in  1  abort the partial block and drop a pending block.
- out512  out  512  assembled block; word k sits at bits [32k+31:32k].
- out_valid  out  1  block complete and held for keccak_ctrl.
- out_ready  in  1  keccak_ctrl accepts the block.
- busy  out  1  high while in HOLD; writes are refused.
- fill_count  out  5  number of distinct slots filled, 0..16.
- dup_err  out  1  sticky: a write hit an already-filled slot.
- ovf_err  out  1  sticky: a write arrived while in HOLD.

Behaviour:
- Reset values: out512=0, out_valid=0, busy=0, fill_count=0, dup_err=0, ovf_err=0, mask=0, state=FILL.
- Storage:
  - 16x32 data registers plus a 16-bit fill mask.
  - out512 is the concatenation of the data registers, driven from registers.
- States:
  - FILL: accepting writes.
  - HOLD: out_valid=1, busy=1, block frozen.
- Write accept condition: en && wr && state==FILL && !clear.
  - At the edge, slot num[3:0] <= in32 and mask bit is set.
  - If the bit was already set: data is overwritten, dup_err <= 1, fill_count is unchanged.
  - Otherwise fill_count increments.
- FILL -> HOLD:
  - Occurs at the edge where the accepted write sets the last mask bit (mask becomes all ones).
  - out_valid rises on the cycle after the completing write (latency 1).
  - Slot order is free; the same applies to any permutation of slot indices.
- HOLD:
  - out512 stays stable; no data register changes.
  - Write strobe (en&&wr) in HOLD: dropped, ovf_err <= 1.
  - out_valid && out_ready at an edge: mask <= 0, fill_count <= 0, state <= FILL.
  - out_valid is low the next cycle; data registers keep their old contents (not zeroed).
  - A write in the same cycle as the accepting handshake is dropped and sets ovf_err.
- out_ready while in FILL has no effect.
- clear (any state):
  - mask <= 0, fill_count <= 0, state <= FILL, out_valid <= 0, dup_err <= 0, ovf_err <= 0.
  - Data registers are retained.
  - clear has priority over a simultaneous write and over a simultaneous handshake.
  - The handshake is not counted: keccak_ctrl must treat valid falling without a completed transfer as an abort.
- rst has priority over everything and also zeroes the data registers. Reset mid-block discards the partial block.
- en=0 only gates writes; a pending HOLD block can still be accepted.

Decomposition:
- Shared keccak package:
  - constants KECCAK_BLK_W=512, KECCAK_WORD_W=32, KECCAK_NWORDS=16.
  - state encoding FILL=1'b0, HOLD=1'b1.
  - index-to-bit-offset function (k*32), shared with the divider so both ends agree on mapping.
- One natural sub-module, keccak_gather_slot: a single 32-bit register with load enable, instantiated 16 times via generate.
- Mask, counter and FSM stay in the top.

Test Plan:
- Reset, then write slots 0..15 with in32=32'h1000_0000+k, one per cycle.
  - Required: out_valid=1 on the cycle after the 16th write, fill_count=16, out512[31:0]=32'h1000_0000, out512[511:480]=32'h1000_000F.
  - Hold out_ready=0 for 5 cycles, then assert it: out_valid stays 1 for 5 cycles and drops 1 cycle after the handshake.
- Write slots in order 15,14,...,0 with num[5:4]=2'b11.
  - Required: same block mapping as in-order writes (num[5:4] ignored), out_valid after the 16th write.
- Write slot 3 twice (32'hAAAA_AAAA then 32'h5555_5555) among 16 distinct writes.
  - Required: dup_err=1, fill_count only reaches 16 after all distinct slots are written, out512[127:96]=32'h5555_5555.
- Write during HOLD (slot 0, 32'hDEAD_BEEF).
  - Required: ovf_err=1, out512[31:0] unchanged, busy=1.
- Write 8 slots, assert clear together with a write to slot 8.
  - Required next cycle: fill_count=0, out_valid=0, errors 0, slot 8 not marked filled.
  - A further 16 writes then complete a block normally.
- Assert rst while in HOLD with out_ready=1.
  - Required: next cycle out_valid=0, out512=0, fill_count=0, no transfer counted.
